// File: rtl/fetch_mem_ctrl.sv
// fetch_mem_ctrl: shares one memory port between instruction fetch and MEM-stage data accesses
module fetch_mem_ctrl #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        stall_pc,
    output logic        pc_branch_flag,
    output logic [31:0] pc_branch_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic        dack,
    output logic [31:0] drdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;
    state_t state, state_nxt;
    logic pending;
    logic [31:0] pend_tgt;
    logic [CW-1:0] wcnt;
    logic busy, is_data, fetch_done;
    // next state and port/handshake outputs; data only wins at a fetch boundary
    always_comb begin
        busy = state != IDLE;
        is_data = state == DACCESS;
        fetch_done = (state == IFETCH) & mem_ready;
        state_nxt = (state == IDLE || fetch_done) ? (dreq ? DACCESS : IFETCH)
                  : (is_data & mem_ready) ? IFETCH : state;
        mem_req = busy;
        mem_we = is_data & dwe;
        mem_addr = is_data ? daddr : pc;
        mem_wdata = is_data ? dwdata : '0;
        dack = is_data & mem_ready;
        drdata = dack ? mem_rdata : '0;
        stall_pc = ~fetch_done;
        pc_branch_flag = branch_flag | pending;
        pc_branch_target = branch_flag ? branch_target : pend_tgt;
    end
    // state, wait watchdog, fetched-instruction register and pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt <= '0;
            bus_err <= 1'b0;
            if_valid <= 1'b0;
            if_inst <= '0;
            if_pc <= '0;
            pending <= 1'b0;
            pend_tgt <= '0;
        end else begin
            state <= state_nxt;
            wcnt <= (!busy || mem_ready) ? '0 : (wcnt == CW'(WAIT_MAX)) ? wcnt : wcnt + CW'(1);
            bus_err <= bus_err | (busy & ~mem_ready & (wcnt == CW'(WAIT_MAX - 1)));
            if_valid <= fetch_done;
            if_inst <= fetch_done ? mem_rdata : if_inst;
            if_pc <= fetch_done ? pc : if_pc;
            pending <= stall_pc & (pending | branch_flag);
            pend_tgt <= (stall_pc & branch_flag) ? branch_target : pend_tgt;
        end
    end
endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// tb_fetch_mem_ctrl: directed bench checking fetch_mem_ctrl against a port-ownership model
module tb_fetch_mem_ctrl;
    localparam int WM = 16;
    logic clk = 0, rst = 1;
    logic [31:0] pc = 0, branch_target = 0, daddr = 0, dwdata = 0, mem_rdata = 0;
    logic branch_flag = 0, dreq = 0, dwe = 0, mem_ready = 0;
    logic stall_pc, pc_branch_flag, if_valid, dack, mem_req, mem_we, bus_err;
    logic [31:0] pc_branch_target, if_inst, if_pc, drdata, mem_addr, mem_wdata;

    fetch_mem_ctrl #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .pc(pc), .branch_flag(branch_flag), .branch_target(branch_target),
        .stall_pc(stall_pc), .pc_branch_flag(pc_branch_flag), .pc_branch_target(pc_branch_target),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .dreq(dreq), .dwe(dwe),
        .daddr(daddr), .dwdata(dwdata), .dack(dack), .drdata(drdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    // model: who owns the port (0 nobody, 1 fetch, 2 data), waits so far, sticky error,
    // pending redirect and the instruction expected on decode's side next cycle
    int owner = 0, waits = 0, dack_cnt = 0;
    bit known = 0, err = 0, pend = 0, q_valid = 0;
    logic [31:0] ptgt = 0, q_inst = 0, q_pc = 0, npc = 0;
    logic s_stall, s_req, s_we, s_dack, s_bflag, s_err, s_valid;
    logic [31:0] s_addr, s_wdata, s_btgt, s_ifpc, s_ifinst, s_rdata;
    logic [31:0] got_pc[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic compare();
        bit fd;
        s_stall = stall_pc; s_req = mem_req; s_we = mem_we; s_dack = dack; s_bflag = pc_branch_flag;
        s_err = bus_err; s_valid = if_valid; s_addr = mem_addr; s_wdata = mem_wdata;
        s_btgt = pc_branch_target; s_ifpc = if_pc; s_ifinst = if_inst; s_rdata = mem_rdata;
        if (dack === 1'b1) dack_cnt++;
        if (if_valid === 1'b1) got_pc.push_back(if_pc);
        if (!known) return;
        fd = owner == 1 && mem_ready;
        chk("stall_pc", {31'b0, stall_pc}, {31'b0, !fd});
        chk("mem_req", {31'b0, mem_req}, {31'b0, owner != 0});
        if (owner != 0) begin
            chk("mem_we", {31'b0, mem_we}, {31'b0, owner == 2 && dwe});
            chk("mem_addr", mem_addr, owner == 2 ? daddr : pc);
        end
        if (owner == 2) chk("mem_wdata", mem_wdata, dwdata);
        chk("dack", {31'b0, dack}, {31'b0, owner == 2 && mem_ready});
        if (owner == 2 && mem_ready) chk("drdata", drdata, mem_rdata);
        chk("pc_branch_flag", {31'b0, pc_branch_flag}, {31'b0, branch_flag || pend});
        if (branch_flag || pend) chk("pc_branch_target", pc_branch_target, branch_flag ? branch_target : ptgt);
        chk("if_valid", {31'b0, if_valid}, {31'b0, q_valid});
        if (q_valid) begin
            chk("if_inst", if_inst, q_inst);
            chk("if_pc", if_pc, q_pc);
        end
        chk("bus_err", {31'b0, bus_err}, {31'b0, err});
    endtask

    task automatic model_step();
        bit fd;
        npc = pc;
        if (rst) begin
            owner = 0; waits = 0; err = 0; pend = 0; ptgt = 0;
            q_valid = 0; q_inst = 0; q_pc = 0; known = 1;
            return;
        end
        if (!known) return;
        fd = owner == 1 && mem_ready;
        if (fd) npc = branch_flag ? branch_target : pend ? ptgt : pc + 4;
        if (fd) pend = 0;
        else if (branch_flag) begin pend = 1; ptgt = branch_target; end
        q_valid = fd;
        if (fd) begin q_inst = mem_rdata; q_pc = pc; end
        if (owner != 0 && !mem_ready) begin
            waits++;
            if (waits >= WM) err = 1;
        end else waits = 0;
        if (owner == 0) owner = dreq ? 2 : 1;
        else if (mem_ready) owner = (owner == 1 && dreq) ? 2 : 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        pc = npc;
        mem_rdata = $urandom;
    endtask

    initial begin
        logic [31:0] rd;
        int d0;
        cycle(); cycle();
        rst = 0; mem_ready = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("zero_wait_count", got_pc.size(), 4);
        chk("zero_wait_pc0", got_pc[0], 32'h0);
        chk("zero_wait_pc1", got_pc[1], 32'h4);
        chk("zero_wait_pc2", got_pc[2], 32'h8);
        chk("zero_wait_err", {31'b0, s_err}, 0);

        pc = 32'h100; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wait_stall", {31'b0, s_stall}, 1);
            chk("wait_addr", s_addr, 32'h100);
        end
        mem_ready = 1; cycle();
        rd = s_rdata;
        chk("wait_done_stall", {31'b0, s_stall}, 0);
        chk("wait_done_addr", s_addr, 32'h100);
        mem_ready = 0; cycle();
        chk("wait_if_valid", {31'b0, s_valid}, 1);
        chk("wait_if_pc", s_ifpc, 32'h100);
        chk("wait_if_inst", s_ifinst, rd);

        d0 = dack_cnt;
        dreq = 1; dwe = 1; daddr = 32'h2000; dwdata = 32'hDEADBEEF; cycle();
        chk("midfetch_we", {31'b0, s_we}, 0);
        chk("midfetch_addr", s_addr, 32'h104);
        mem_ready = 1; cycle();
        chk("midfetch_done", {31'b0, s_stall}, 0);
        cycle();
        chk("store_we", {31'b0, s_we}, 1);
        chk("store_addr", s_addr, 32'h2000);
        chk("store_wdata", s_wdata, 32'hDEADBEEF);
        chk("store_dack", {31'b0, s_dack}, 1);
        chk("store_stall", {31'b0, s_stall}, 1);
        mem_ready = 0; cycle();
        chk("after_store_we", {31'b0, s_we}, 0);
        chk("after_store_addr", s_addr, 32'h108);
        chk("after_store_dack", {31'b0, s_dack}, 0);
        dreq = 0; dwe = 0; mem_ready = 1; cycle();
        chk("dack_once", dack_cnt - d0, 1);

        mem_ready = 0; branch_flag = 1; branch_target = 32'h400; cycle();
        chk("br_now_flag", {31'b0, s_bflag}, 1);
        chk("br_now_tgt", s_btgt, 32'h400);
        branch_flag = 0; cycle();
        chk("br_pend_flag", {31'b0, s_bflag}, 1);
        chk("br_pend_tgt", s_btgt, 32'h400);
        mem_ready = 1; cycle();
        chk("br_take_flag", {31'b0, s_bflag}, 1);
        chk("br_take_tgt", s_btgt, 32'h400);
        chk("br_take_stall", {31'b0, s_stall}, 0);
        mem_ready = 0; cycle();
        chk("br_cleared", {31'b0, s_bflag}, 0);
        chk("br_new_addr", s_addr, 32'h400);
        branch_flag = 1; branch_target = 32'h600; cycle();
        branch_target = 32'h800; cycle();
        branch_flag = 0; mem_ready = 1; cycle();
        chk("br2_tgt", s_btgt, 32'h800);
        cycle();
        chk("br2_addr", s_addr, 32'h800);
        chk("br2_cleared", {31'b0, s_bflag}, 0);

        mem_ready = 0;
        for (int i = 1; i <= WM + 2; i++) begin
            cycle();
            chk($sformatf("watchdog_%0d", i), {31'b0, s_err}, {31'b0, i > WM});
        end
        mem_ready = 1; cycle();
        chk("err_sticky0", {31'b0, s_err}, 1);
        cycle();
        chk("err_sticky1", {31'b0, s_err}, 1);

        dreq = 1; daddr = 32'h3000; cycle();
        mem_ready = 0; rst = 1; branch_flag = 1; branch_target = 32'hABC; cycle();
        chk("rst_in_data_addr", s_addr, 32'h3000);
        chk("rst_in_data_req", {31'b0, s_req}, 1);
        rst = 0; dreq = 0; branch_flag = 0; mem_ready = 1; cycle();
        chk("rst_idle_req", {31'b0, s_req}, 0);
        chk("rst_idle_dack", {31'b0, s_dack}, 0);
        chk("rst_idle_err", {31'b0, s_err}, 0);
        chk("rst_idle_bflag", {31'b0, s_bflag}, 0);
        chk("rst_idle_stall", {31'b0, s_stall}, 1);
        cycle();
        chk("resume_req", {31'b0, s_req}, 1);
        chk("resume_we", {31'b0, s_we}, 0);
        chk("resume_stall", {31'b0, s_stall}, 0);
        cycle(); cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_mem_ctrl.md
Name: fetch_mem_ctrl

Overview:
- Sequences the fetch stage around the program counter.
- Shares a single-port memory between instruction fetch (address = pc) and data load/store requests from the MEM stage.
- Holds the pc while a fetch is outstanding or data owns the port, and delivers registered fetched instructions to decode.
- Latches branch redirects from decode and releases them to the pc on the cycle the pc advances.

Parameters:
- WAIT_MAX, 16: max cycles a memory access may wait for mem_ready before bus_err is raised (≥1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  32  current fetch address from the pc register
- branch_flag  in  1  one-cycle branch-taken pulse from decode
- branch_target  in  32  redirect address, valid with branch_flag
- stall_pc  out  1  1 = pc must hold its value this cycle
- pc_branch_flag  out  1  to pc: load pc_branch_target instead of pc+4
- pc_branch_target  out  32  redirect address to pc
- if_valid  out  1  registered pulse: if_inst/if_pc valid
- if_inst  out  32  fetched instruction
- if_pc  out  32  address of if_inst
- dreq  in  1  data request, held stable until dack
- dwe  in  1  1 = store, 0 = load
- daddr  in  32  data address
- dwdata  in  32  store data
- dack  out  1  data access complete this cycle
- drdata  out  32  load data, valid with dack
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current access
- bus_err  out  1  sticky: an access exceeded WAIT_MAX cycles

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state to IDLE
  - branch pending and target to 0
  - wait counter to 0
  - if_valid, if_inst, if_pc and bus_err to 0
- Reset applies mid-access: any outstanding access is abandoned and mem_req is low the cycle after the reset edge.
- States: IDLE, IFETCH, DACCESS.
  - IDLE: mem_req=0, stall_pc=1. Next state is DACCESS if dreq=1, else IFETCH.
  - IFETCH: mem_req=1, mem_we=0, mem_addr=pc. The pc is stable because stall_pc=1 until completion.
    - Completion is mem_ready=1. In that cycle stall_pc=0, so the pc advances on that edge.
    - At completion: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1 for exactly one cycle.
    - After completion, next state is DACCESS if dreq=1, else IFETCH (back-to-back fetches).
  - DACCESS: mem_req=1, mem_we=dwe, mem_addr=daddr, mem_wdata=dwdata.
    - On mem_ready: dack=1 and drdata=mem_rdata, both combinational in that cycle.
    - Next state is always IFETCH, so one fetch is guaranteed between data accesses.
- stall_pc = ~(state==IFETCH & mem_ready). It is 1 in IDLE and DACCESS.
- Arbitration:
  - Data has priority only at a fetch boundary.
  - An in-flight fetch is never aborted.
  - dreq arriving mid-fetch waits until that fetch completes.
- Branch handling:
  - pc_branch_flag = branch_flag | pending.
  - pc_branch_target = branch_flag ? branch_target : stored target. A new branch wins over a pending one.
  - If branch_flag=1 and stall_pc=1: set pending and store branch_target.
  - When stall_pc=0 (pc consumes the redirect): clear pending.
  - The instruction fetched in the same cycle as the redirect is delivered normally (branch delay slot).
- Wait counter:
  - Clears on state entry and on each completion.
  - Increments every IFETCH/DACCESS cycle with mem_ready=0.
  - When it reaches WAIT_MAX, bus_err<=1, sticky until rst.
  - The access continues waiting; there is no abort.
- Widths: if_pc is captured at full 32 bits. No wrap or alignment checks; pc arithmetic belongs to the pc register.
- mem_ready outside IFETCH/DACCESS is ignored.

Test Plan:
- Reset, then zero-wait memory (mem_ready=1 every cycle), pc advancing 0,4,8 → if_valid pulses every cycle from cycle 2 with if_pc=0,4,8; stall_pc=0 during IFETCH; bus_err=0.
- 3-wait memory, pc=0x100 → mem_addr held 0x100 for 4 cycles; stall_pc=1 for 3 cycles, 0 on the 4th; if_inst=mem_rdata, if_pc=0x100.
- dreq (store, daddr=0x2000, dwdata=0xDEADBEEF) raised mid-fetch → fetch completes first, then DACCESS with mem_we=1 and mem_addr=0x2000; dack pulses once; next access is IFETCH even with dreq still high.
- branch_flag pulse (target 0x400) during a 2-wait fetch → pending held; pc_branch_flag=1 with target 0x400 on the completion cycle; pending cleared afterwards. A second branch to 0x800 arriving before consumption → 0x800 delivered.
- mem_ready held low for WAIT_MAX+2 cycles → bus_err rises after WAIT_MAX waits and stays 1 after mem_ready returns.
- rst asserted during DACCESS → next cycle state IDLE, mem_req=0, dack=0, bus_err=0, pending=0; operation then resumes with IFETCH.
